// File: rtl/div_fu_ctrl.sv
// div_fu_ctrl
// Controller between the divide reservation station and an iterative
// 64-bit divider. It accepts one tagged op at a time and resolves the RISC-V
// special cases (x/0 and MIN/-1) locally. Every other op goes through the
// divider's valid/ready/yumi handshake. The result is held on the CDB until
// the arbiter grants it. A flush squashes the op and drains the divider.
//
// Optional feature: define DIV_FU_W_EN to honour issue_word_i (32-bit W ops).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   issue_valid_i/ready_o      op handshake from the reservation station
//   issue_tag_i                ROB tag of the op
//   issue_signed_i             1 = DIV, 0 = DIVU
//   issue_word_i               32-bit op (used only with DIV_FU_W_EN)
//   issue_a_i/issue_b_i        dividend/divisor
//   flush_i                    kill any op held in the unit
//   div_valid_o/div_ready_i    request handshake to the divider
//   div_signed_o               signed-divide select to the divider
//   div_dividend_o/divisor_o   registered operands to the divider
//   div_valid_i/div_quotient_i divider result
//   div_yumi_o                 result consumed by this unit
//   cdb_valid_o/cdb_grant_i    CDB broadcast request/grant
//   cdb_tag_o/cdb_data_o       broadcast tag and value
module div_fu_ctrl #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             issue_signed_i,
    input  logic             issue_word_i,
    input  logic [63:0]      issue_a_i,
    input  logic [63:0]      issue_b_i,
    input  logic             flush_i,
    output logic             div_valid_o,
    input  logic             div_ready_i,
    output logic             div_signed_o,
    output logic [63:0]      div_dividend_o,
    output logic [63:0]      div_divisor_o,
    input  logic             div_valid_i,
    input  logic [63:0]      div_quotient_i,
    output logic             div_yumi_o,
    output logic             cdb_valid_o,
    input  logic             cdb_grant_i,
    output logic [TAG_W-1:0] cdb_tag_o,
    output logic [63:0]      cdb_data_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, WB} state_e;

    state_e           state_q;
    logic [TAG_W-1:0] tag_q;
    logic             signed_q;
    logic [63:0]      dividend_q;
    logic [63:0]      divisor_q;
    logic [63:0]      cdbData_q;

    logic        accept;
    logic        divHandshake;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        isDivZero;
    logic        isOverflow;
    logic [63:0] specialResult;
    logic [63:0] quotientPost;

`ifdef DIV_FU_W_EN
    logic word_q;

    // W ops work on the low 32 bits, extended to 64 according to signedness,
    // and their result is the sign-extended low word.
    always_comb begin
        opA           = issue_a_i;
        opB           = issue_b_i;
        isDivZero     = (issue_b_i == 64'd0);
        isOverflow    = issue_signed_i && (issue_a_i == 64'h8000_0000_0000_0000)
                        && (issue_b_i == '1);
        specialResult = isDivZero ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
        if (issue_word_i) begin
            opA           = {{32{issue_a_i[31] & issue_signed_i}}, issue_a_i[31:0]};
            opB           = {{32{issue_b_i[31] & issue_signed_i}}, issue_b_i[31:0]};
            isDivZero     = (issue_b_i[31:0] == 32'd0);
            isOverflow    = issue_signed_i && (issue_a_i[31:0] == 32'h8000_0000)
                            && (issue_b_i[31:0] == 32'hFFFF_FFFF);
            specialResult = isDivZero ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_8000_0000;
        end
        quotientPost = word_q ? {{32{div_quotient_i[31]}}, div_quotient_i[31:0]}
                              : div_quotient_i;
    end
`else
    logic unusedWord;
    assign unusedWord = issue_word_i;

    always_comb begin
        opA           = issue_a_i;
        opB           = issue_b_i;
        isDivZero     = (issue_b_i == 64'd0);
        isOverflow    = issue_signed_i && (issue_a_i == 64'h8000_0000_0000_0000)
                        && (issue_b_i == '1);
        specialResult = isDivZero ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
        quotientPost  = div_quotient_i;
    end
`endif

    // A flush in IDLE blocks the accept so a squashed op never enters.
    assign accept       = issue_valid_i && !flush_i;
    assign divHandshake = div_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            signed_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            cdbData_q  <= '0;
`ifdef DIV_FU_W_EN
            word_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        tag_q      <= issue_tag_i;
                        signed_q   <= issue_signed_i;
                        dividend_q <= opA;
                        divisor_q  <= opB;
`ifdef DIV_FU_W_EN
                        word_q     <= issue_word_i;
`endif
                        if (isDivZero || isOverflow) begin
                            cdbData_q <= specialResult;
                            state_q   <= WB;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                // If the divider took the op in the flush cycle it still
                // owes a result, so that result must be drained.
                ISSUE: begin
                    if (flush_i) begin
                        state_q <= divHandshake ? DRAIN : IDLE;
                    end else if (divHandshake) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        state_q <= div_valid_i ? IDLE : DRAIN;
                    end else if (div_valid_i) begin
                        cdbData_q <= quotientPost;
                        state_q   <= WB;
                    end
                end
                DRAIN: begin
                    if (div_valid_i) begin
                        state_q <= IDLE;
                    end
                end
                WB: begin
                    if (flush_i || cdb_grant_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign issue_ready_o  = (state_q == IDLE);
    assign div_valid_o    = (state_q == ISSUE);
    assign div_signed_o   = signed_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    // The result is consumed in the same cycle it is offered, whether it is kept or dropped.
    assign div_yumi_o     = ((state_q == WAIT) || (state_q == DRAIN)) && div_valid_i;
    assign cdb_valid_o    = (state_q == WB);
    assign cdb_tag_o      = tag_q;
    assign cdb_data_o     = cdbData_q;

endmodule

// File: tb/tb_div_fu_ctrl.sv
// Testbench for div_fu_ctrl. A behavioural divider with programmable latency
// answers the handshake. Expected CDB results go into a scoreboard queue.
// A negedge monitor checks them against what the DUT broadcasts.
module tb_div_fu_ctrl;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [TAG_W-1:0] issue_tag_i;
    logic             issue_signed_i;
    logic             issue_word_i;
    logic [63:0]      issue_a_i;
    logic [63:0]      issue_b_i;
    logic             flush_i;
    logic             div_valid_o;
    logic             div_ready_i;
    logic             div_signed_o;
    logic [63:0]      div_dividend_o;
    logic [63:0]      div_divisor_o;
    logic             div_valid_i;
    logic [63:0]      div_quotient_i;
    logic             div_yumi_o;
    logic             cdb_valid_o;
    logic             cdb_grant_i;
    logic [TAG_W-1:0] cdb_tag_o;
    logic [63:0]      cdb_data_o;

    div_fu_ctrl #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_tag_i    (issue_tag_i),
        .issue_signed_i (issue_signed_i),
        .issue_word_i   (issue_word_i),
        .issue_a_i      (issue_a_i),
        .issue_b_i      (issue_b_i),
        .flush_i        (flush_i),
        .div_valid_o    (div_valid_o),
        .div_ready_i    (div_ready_i),
        .div_signed_o   (div_signed_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_valid_i    (div_valid_i),
        .div_quotient_i (div_quotient_i),
        .div_yumi_o     (div_yumi_o),
        .cdb_valid_o    (cdb_valid_o),
        .cdb_grant_i    (cdb_grant_i),
        .cdb_tag_o      (cdb_tag_o),
        .cdb_data_o     (cdb_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad = 0;
    int   cdbCycles = 0;
    int   divValidCycles = 0;
    int   yumiCount = 0;
    int   hsCount = 0;
    int   divLatency = 4;

    // Behavioural iterative divider
    logic        divBusy;
    int          divCnt;
    logic [63:0] divRes;

    function automatic logic [63:0] refDiv(input logic s, input logic [63:0] a, input logic [63:0] b);
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    assign div_ready_i = !divBusy && !div_valid_i;

    always @(posedge clk) begin
        if (reset) begin
            divBusy        <= 1'b0;
            div_valid_i    <= 1'b0;
            div_quotient_i <= '0;
            divCnt         <= 0;
        end else if (div_valid_i && div_yumi_o) begin
            div_valid_i <= 1'b0;
        end else if (divBusy) begin
            if (divCnt == 0) begin
                divBusy        <= 1'b0;
                div_valid_i    <= 1'b1;
                div_quotient_i <= divRes;
            end else begin
                divCnt <= divCnt - 1;
            end
        end else if (div_valid_o && div_ready_i) begin
            divBusy <= 1'b1;
            divCnt  <= divLatency - 1;
            divRes  <= refDiv(div_signed_o, div_dividend_o, div_divisor_o);
            hsCount <= hsCount + 1;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (cdb_valid_o) cdbCycles++;
            if (div_valid_o) divValidCycles++;
            if (div_yumi_o) begin
                yumiCount++;
                total++;
                if (!div_valid_i) begin
                    bad++;
                    $display("[TB] FAIL yumiWithoutValid: div_valid_i=%0b required=1", div_valid_i);
                end
            end
            if (cdb_valid_o && sbQ.size() > 0) begin
                total++;
                if (cdb_tag_o !== sbQ[0].tag || cdb_data_o !== sbQ[0].data) begin
                    bad++;
                    $display("[TB] FAIL cdbResult: got tag=%0d data=%h required tag=%0d data=%h",
                             cdb_tag_o, cdb_data_o, sbQ[0].tag, sbQ[0].data);
                end
            end
            if (cdb_valid_o && cdb_grant_i && !flush_i) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedBroadcast: tag=%0d data=%h required none",
                             cdb_tag_o, cdb_data_o);
                end else begin
                    void'(sbQ.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic sgn, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!issue_ready_o && n < 200) begin
            tick();
            n++;
        end
        checkOutput("issueReadyBeforeOp", {63'd0, issue_ready_o}, 64'd1);
        issue_valid_i  = 1'b1;
        issue_tag_i    = tag;
        issue_signed_i = sgn;
        issue_word_i   = word;
        issue_a_i      = a;
        issue_b_i      = b;
        tick();
        issue_valid_i  = 1'b0;
    endtask

    task automatic waitCdb();
        int n = 0;
        while (!cdb_valid_o && n < 200) begin
            tick();
            n++;
        end
        checkOutput("cdbArrives", {63'd0, cdb_valid_o}, 64'd1);
    endtask

    // Hold off the grant for 'delay' cycles, then grant once.
    task automatic grantAfter(input int delay);
        int c0 = cdbCycles;
        for (int i = 0; i < delay; i++) begin
            checkOutput("cdbHeld", {63'd0, cdb_valid_o}, 64'd1);
            tick();
        end
        cdb_grant_i = 1'b1;
        tick();
        cdb_grant_i = 1'b0;
        checkOutput("cdbDropsAfterGrant", {63'd0, cdb_valid_o}, 64'd0);
        checkOutput("readyAfterGrant", {63'd0, issue_ready_o}, 64'd1);
        checkOutput("cdbCycleCount", 64'(cdbCycles - c0), 64'(delay + 1));
    endtask

    task automatic runNormal(input logic [TAG_W-1:0] tag, input logic sgn, input logic word,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] expData, input int delay);
        int hs0 = hsCount;
        int y0  = yumiCount;
        exp_t e;
        e.tag  = tag;
        e.data = expData;
        sbQ.push_back(e);
        applyStimulus(tag, sgn, word, a, b);
        checkOutput("divValidCycle1", {63'd0, div_valid_o}, 64'd1);
        waitCdb();
        grantAfter(delay);
        checkOutput("oneHandshake", 64'(hsCount - hs0), 64'd1);
        checkOutput("oneYumi", 64'(yumiCount - y0), 64'd1);
    endtask

    task automatic runSpecial(input logic [TAG_W-1:0] tag, input logic sgn,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] expData);
        int dv0 = divValidCycles;
        exp_t e;
        e.tag  = tag;
        e.data = expData;
        sbQ.push_back(e);
        applyStimulus(tag, sgn, 1'b0, a, b);
        checkOutput("specialCdbLatency1", {63'd0, cdb_valid_o}, 64'd1);
        checkOutput("specialNoDivValid", {63'd0, div_valid_o}, 64'd0);
        grantAfter(0);
        checkOutput("specialNoDivValidCount", 64'(divValidCycles - dv0), 64'd0);
    endtask

    task automatic waitYumiThenIdle();
        int n = 0;
        while (!div_yumi_o && n < 200) begin
            tick();
            n++;
        end
        checkOutput("drainYumiSeen", {63'd0, div_yumi_o}, 64'd1);
        tick();
        checkOutput("readyAfterDrain", {63'd0, issue_ready_o}, 64'd1);
    endtask

    initial begin
        int c0;
        int y0;
        reset          = 1'b1;
        issue_valid_i  = 1'b0;
        issue_tag_i    = '0;
        issue_signed_i = 1'b0;
        issue_word_i   = 1'b0;
        issue_a_i      = '0;
        issue_b_i      = '0;
        flush_i        = 1'b0;
        cdb_grant_i    = 1'b0;
        repeat (3) tick();
        checkOutput("resetReady", {63'd0, issue_ready_o}, 64'd1);
        checkOutput("resetDivValid", {63'd0, div_valid_o}, 64'd0);
        checkOutput("resetCdbValid", {63'd0, cdb_valid_o}, 64'd0);
        checkOutput("resetYumi", {63'd0, div_yumi_o}, 64'd0);
        checkOutput("resetCdbData", cdb_data_o, 64'd0);
        checkOutput("resetDividend", div_dividend_o, 64'd0);
        reset = 1'b0;
        tick();

        // Normal divides
        runNormal(6'd5, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 0);
        runNormal(6'd9, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFCE, 64'd5, 64'hFFFF_FFFF_FFFF_FFF6, 3);

        // Special cases
        runSpecial(6'd1, 1'b1, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        runSpecial(6'd2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        runSpecial(6'd4, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush 10 cycles into WAIT
        divLatency = 20;
        c0 = cdbCycles;
        y0 = yumiCount;
        applyStimulus(6'd3, 1'b0, 1'b0, 64'd1000, 64'd3);
        tick();
        repeat (10) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        waitYumiThenIdle();
        checkOutput("waitFlushOneYumi", 64'(yumiCount - y0), 64'd1);
        checkOutput("waitFlushNoCdb", 64'(cdbCycles - c0), 64'd0);
        divLatency = 4;
        runNormal(6'd11, 1'b0, 1'b0, 64'd12, 64'd4, 64'd3, 1);

        // Flush in ISSUE coinciding with the divider handshake
        c0 = cdbCycles;
        y0 = yumiCount;
        applyStimulus(6'd12, 1'b0, 1'b0, 64'd50, 64'd6);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        waitYumiThenIdle();
        checkOutput("issueFlushOneYumi", 64'(yumiCount - y0), 64'd1);
        checkOutput("issueFlushNoCdb", 64'(cdbCycles - c0), 64'd0);

        // Flush in WB together with grant
        applyStimulus(6'd7, 1'b0, 1'b0, 64'd9, 64'd3);
        waitCdb();
        flush_i     = 1'b1;
        cdb_grant_i = 1'b1;
        tick();
        flush_i     = 1'b0;
        cdb_grant_i = 1'b0;
        checkOutput("wbFlushCdbDrop", {63'd0, cdb_valid_o}, 64'd0);
        checkOutput("wbFlushReady", {63'd0, issue_ready_o}, 64'd1);

        // Flush with issue_valid_i in IDLE
        issue_valid_i = 1'b1;
        issue_a_i     = 64'd8;
        issue_b_i     = 64'd0;
        flush_i       = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
        checkOutput("idleFlushNotAccepted", {63'd0, issue_ready_o}, 64'd1);
        checkOutput("idleFlushNoCdb", {63'd0, cdb_valid_o}, 64'd0);
        checkOutput("idleFlushNoDivValid", {63'd0, div_valid_o}, 64'd0);

        // W op: 32-bit result only when the feature is built in
`ifdef DIV_FU_W_EN
        runNormal(6'd20, 1'b1, 1'b1, 64'h1_FFFF_FFF0, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 0);
`else
        runNormal(6'd20, 1'b1, 1'b1, 64'h1_FFFF_FFF0, 64'd2, 64'h0000_0000_FFFF_FFF8, 0);
`endif

        // Reset mid-operation
        divLatency = 6;
        applyStimulus(6'd21, 1'b0, 1'b0, 64'd77, 64'd7);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midResetReady", {63'd0, issue_ready_o}, 64'd1);
        checkOutput("midResetCdb", {63'd0, cdb_valid_o}, 64'd0);
        checkOutput("midResetDivValid", {63'd0, div_valid_o}, 64'd0);
        runNormal(6'd22, 1'b0, 1'b0, 64'd77, 64'd7, 64'd11, 0);

        tick();
        checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
